ps2_rx_frame: RTL and testbench

//  PS/2 device-to-host receiver for the keyboard path. Synchronises and filters raw ps2clk/ps2data,

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_rx_frame.sv | 112 +++++++++++
 tb/tb_ps2_rx_frame.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame constants and the break code
// used by the downstream key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int         PS2_DATA_BITS  = 8;
  localparam logic       PS2_START_BIT  = 1'b0;
  localparam logic       PS2_STOP_BIT   = 1'b1;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  // Odd parity across the data byte and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a debounce: the output follows the line only after
// FILTER_LEN consecutive synchronised samples disagree with it. Idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_line
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_out;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset values match an idle (high) bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_out  <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] != r_out) begin
        if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_out <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_line = r_out;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: filters ps2clk/ps2data, deframes 11-bit frames and
// strobes each good byte. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_err
);

  localparam int             TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic w_clk_f;
  logic w_data_f;
  logic w_fall;
  logic w_frame_good;

  ps2_state_t      r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shreg;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_clk_prev;

  // Data goes through an identical filter so it keeps its alignment with the filtered clock.
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .i_line(ps2clk), .o_line(w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .i_line(ps2data), .o_line(w_data_f)
  );

  assign w_fall = r_clk_prev & ~w_clk_f;

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  assign w_frame_good = (w_data_f == PS2_STOP_BIT) && odd_parity_ok(r_shreg, r_parity);
`else
  assign w_frame_good = (w_data_f == PS2_STOP_BIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_bit_cnt        <= '0;
      r_shreg          <= '0;
      r_to_cnt         <= '0;
      r_clk_prev       <= 1'b1;
      received_data    <= '0;
      received_data_en <= 1'b0;
      frame_err        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity         <= 1'b0;
`endif
    end else begin
      r_clk_prev       <= w_clk_f;
      received_data_en <= 1'b0;
      frame_err        <= 1'b0;
      // A fall always takes priority over an expiring timeout.
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          IDLE: begin
            if (w_data_f == PS2_START_BIT) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          DATA: begin
            r_shreg <= {w_data_f, r_shreg[7:1]};
            if (r_bit_cnt == LAST_BIT) r_state <= PARITY;
            else r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity <= w_data_f;
`endif
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (w_frame_good) begin
              received_data    <= r_shreg;
              received_data_en <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_state   <= IDLE;
          r_to_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: frames are built from random bytes, the expected
// outcome is queued from the framing rules, and a monitor checks every strobe.
module tb_ps2_rx_frame;
  import ps2_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int HALF           = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_err;

  always #10 clk = ~clk;

  ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .received_data(received_data), .received_data_en(received_data_en), .frame_err(frame_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;   // value received_data must show at the event
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          events = 0;
  int unsigned cyc = 0;
  int unsigned last_evt_cyc = 0;
  int unsigned last_fall_cyc = 0;
  logic [7:0]  model_data = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame is accepted iff the stop bit is 1 and, with parity checking,
  // the nine data+parity bits hold an odd number of ones.
  function automatic bit frame_good(input logic [7:0] d, input logic p, input logic stop);
`ifdef PS2_PARITY_CHECK_EN
    return (stop == 1'b1) && ($countones({d, p}) % 2 == 1);
`else
    return (stop == 1'b1);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && (received_data_en === 1'b1 || frame_err === 1'b1)) begin
      events++;
      last_evt_cyc = cyc;
      check("strobe_exclusive", {31'b0, received_data_en & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got en=%0b err=%0b data=%0h expected none",
                 received_data_en, frame_err, received_data);
      end else begin
        mon_e = sb.pop_front();
        check("event_is_err", {31'b0, frame_err}, {31'b0, mon_e.is_err});
        check("received_data", {24'b0, received_data}, {24'b0, mon_e.data});
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p, input logic stop);
    if (frame_good(d, p, stop)) begin
      model_data = d;
      sb.push_back('{is_err: 1'b0, data: d});
    end else begin
      sb.push_back('{is_err: 1'b1, data: model_data});
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    expect_frame(d, p, stop);
    send_bits({stop, p, d, PS2_START_BIT}, 11);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data", {24'b0, received_data}, 32'd0);
    check("reset_en", {31'b0, received_data_en}, 32'd0);
    check("reset_err", {31'b0, frame_err}, 32'd0);
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    model_data = 8'h00;
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev0;
    int unsigned lat;
    logic [7:0] d;
    logic p, stop;

    rst = 1'b1; ps2clk = 1'b1; ps2data = 1'b1;
    do_reset();

    // Single good frame, then back-to-back break + make codes.
    send_frame(8'h1C, ~^8'h1C, 1'b1);
    drain("drain_single");
    send_frame(PS2_BREAK_CODE, ~^PS2_BREAK_CODE, 1'b1);
    send_frame(8'h1C, ~^8'h1C, 1'b1);
    drain("drain_back_to_back");

    // Bad stop bit, then recovery; wrong parity bit.
    send_frame(8'h1C, ~^8'h1C, 1'b0);
    send_frame(8'h15, ~^8'h15, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("drain_stop_parity");

    // Short low glitch on an idle clock line must be invisible.
    ev0 = events;
    @(negedge clk); ps2clk = 1'b0;
    repeat (3) @(negedge clk); ps2clk = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_event", events, ev0);

    // Stall after the start bit and five data bits: timeout abort, then a good frame.
    sb.push_back('{is_err: 1'b1, data: model_data});
    ev0 = events;
    send_bits({1'b1, ~^8'h29, 8'h29, 1'b0}, 6);
    for (int i = 0; i < TIMEOUT_CYCLES + 200 && events == ev0; i++) @(negedge clk);
    check("timeout_fired", {31'b0, events != ev0}, 32'd1);
    lat = last_evt_cyc - last_fall_cyc;
    check("timeout_latency", {31'b0, (lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + 20)}, 32'd1);
    send_frame(8'h29, ~^8'h29, 1'b1);
    drain("drain_timeout");

    // Reset in the middle of a frame aborts it silently.
    send_bits({1'b1, ~^8'h33, 8'h33, 1'b0}, 4);
    do_reset();
    send_frame(8'h5A, ~^8'h5A, 1'b1);
    drain("drain_mid_reset");

    // Randomised frames with occasional bad stop or parity bits.
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      p    = ($urandom_range(0, 5) == 0) ? ^d : ~^d;
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, p, stop);
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    drain("drain_random");

    repeat (50) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
